stopwatch_core: RTL

- Consumer end of the tick-strobe interface. Takes the single-cycle enable strobes from the clock divider and turns them into a BCD MM:SS count with run/pause, clear and field-adjust.
- Outputs drive the seven-segment scanner, including per-field blanking for the adjust-mode blink.
- Every strobe is a one-clk-wide enable in the clk domain. No derived clocks are used.

---
 rtl/stopwatch_if.sv | 31 +++
 rtl/stopwatch_core.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_if.sv
// Stopwatch control and display bundle: tick strobes and user pulses in,
// BCD digits, field blanking and status out.
interface stopwatch_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       tick_blink;
  logic       pause_p;
  logic       clear_p;
  logic       adj;
  logic       sel;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       blank_min;
  logic       blank_sec;
  logic       running;
  logic       wrap;

  modport master (
    output tick_1hz, tick_2hz, tick_blink, pause_p, clear_p, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  blank_min, blank_sec, running, wrap
  );

  modport slave (
    input  tick_1hz, tick_2hz, tick_blink, pause_p, clear_p, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones,
    output blank_min, blank_sec, running, wrap
  );
endinterface

// File: rtl/stopwatch_core.sv
// BCD MM:SS stopwatch driven by single-cycle enable strobes. Supports
// run/pause, clear, and per-field adjust with blink blanking for the scanner.
module stopwatch_core #(
  parameter int MIN_LIMIT = 59,
  parameter int SEC_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  stopwatch_if.slave bus
);

  typedef enum logic {
    NORMAL = 1'b0,
    ADJUST = 1'b1
  } mode_t;

  localparam logic [7:0] MIN_LIM_BCD = {4'(MIN_LIMIT / 10), 4'(MIN_LIMIT % 10)};
  localparam logic [7:0] SEC_LIM_BCD = {4'(SEC_LIMIT / 10), 4'(SEC_LIMIT % 10)};

  // Two-digit BCD increment with wrap at the field limit.
  // Result is {carry, tens, ones}; carry is set when the field wraps to 00.
  function automatic logic [8:0] bcd_inc(input logic [7:0] field,
                                         input logic [7:0] limit);
    if (field == limit)
      return 9'h000 | 9'h100;
    if (field[3:0] == 4'd9)
      return {1'b0, field[7:4] + 4'd1, 4'd0};
    return {1'b0, field[7:4], field[3:0] + 4'd1};
  endfunction

  mode_t      mode;
  mode_t      mode_next;

  logic [7:0] min_q, sec_q;
  logic       running_q, phase_q, wrap_q;
  logic       blank_min_q, blank_sec_q;

  logic       count_en, step_en, pause_en, blink_en;
  logic [7:0] min_d, sec_d;
  logic       running_d, phase_d, wrap_d;
  logic       blank_min_d, blank_sec_d;
  logic [8:0] sec_inc, min_inc;

  // Mode state register; adj is sampled here so all logic sees it one cycle late.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode <= NORMAL;
    else        mode <= mode_next;
  end

  // Next-state: the mode simply follows the adj level.
  always_comb begin
    mode_next = bus.adj ? ADJUST : NORMAL;
  end

  // Mode-dependent enables; clear_p overrides every strobe in the same cycle.
  always_comb begin
    count_en = (mode == NORMAL) && running_q && bus.tick_1hz && !bus.clear_p;
    step_en  = (mode == ADJUST) && bus.tick_2hz && !bus.clear_p;
    pause_en = (mode == NORMAL) && bus.pause_p  && !bus.clear_p;
    blink_en = (mode == ADJUST) && bus.tick_blink && !bus.clear_p;
  end

  assign sec_inc = bcd_inc(sec_q, SEC_LIM_BCD);
  assign min_inc = bcd_inc(min_q, MIN_LIM_BCD);

  // Next count, run flag, wrap pulse, blink phase and field blanks.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    min_d       = min_q;
    sec_d       = sec_q;
    running_d   = running_q;
    wrap_d      = 1'b0;
    phase_d     = phase_q;
    blank_min_d = 1'b0;
    blank_sec_d = 1'b0;

    if (bus.clear_p) begin
      min_d     = 8'h00;
      sec_d     = 8'h00;
      running_d = 1'b0;
    end else begin
      if (count_en) begin
        sec_d = sec_inc[7:0];
        if (sec_inc[8]) begin
          min_d  = min_inc[7:0];
          wrap_d = min_inc[8];
        end
      end
      if (step_en) begin
        if (bus.sel) sec_d = sec_inc[7:0];
        else         min_d = min_inc[7:0];
      end
      // Tick above already saw the pre-toggle running value.
      if (pause_en) running_d = ~running_q;
    end

    // Phase is parked at 1 outside ADJUST so every entry starts visible.
    if (mode == NORMAL) phase_d = 1'b1;
    else if (blink_en)  phase_d = ~phase_q;

    if (mode == ADJUST) begin
      blank_min_d = ~bus.sel & ~phase_d;
      blank_sec_d =  bus.sel & ~phase_d;
    end
  end

  // Datapath registers: count, status and blanking all come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      running_q   <= 1'b0;
      wrap_q      <= 1'b0;
      phase_q     <= 1'b1;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      min_q       <= min_d;
      sec_q       <= sec_d;
      running_q   <= running_d;
      wrap_q      <= wrap_d;
      phase_q     <= phase_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  assign bus.min_tens  = min_q[7:4];
  assign bus.min_ones  = min_q[3:0];
  assign bus.sec_tens  = sec_q[7:4];
  assign bus.sec_ones  = sec_q[3:0];
  assign bus.running   = running_q;
  assign bus.wrap      = wrap_q;
  assign bus.blank_min = blank_min_q;
  assign bus.blank_sec = blank_sec_q;

endmodule
